// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester-side handshake and the UART_TX control lines
//   that the arbiter sits between.
//
//   req_valid  [NUM_REQ]    per-requester byte available, held until req_ready
//   req_data   [NUM_REQ*8]  byte of requester i on [8*i+7:8*i]
//   req_ready  [NUM_REQ]    one-cycle pulse: requester's byte accepted
//   tx_start               one-cycle pulse to UART_TX
//   tx_byte    [8]          byte to UART_TX, stable for the whole frame
//   tx_busy                frame in progress, from UART_TX
//
//   master: the arbiter's view.  slave: the producers and UART_TX side.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_byte;
  logic                 tx_busy;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_byte
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART_TX between NUM_REQ byte producers with round-robin grants.
//   Each grant latches one byte, pulses tx_start for one cycle, then follows
//   tx_busy until the frame ends. If tx_busy never rises within BUSY_TIMEOUT
//   cycles the grant is abandoned (not retried) and busy_timeout pulses.
//
//   clk           system clock, posedge
//   rst           synchronous reset, active-high
//   bus           uart_tx_arbiter_if.master (requesters + UART_TX control)
//   grant_id      index of the current or last granted requester
//   tx_done       one-cycle pulse when the granted frame completes
//   busy_timeout  one-cycle pulse when tx_busy never rose after tx_start
//
//   All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_arbiter_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_done,
  output logic                       busy_timeout
);

  localparam int              IDW      = $clog2(NUM_REQ);
  localparam int              CW       = $clog2(BUSY_TIMEOUT);
  localparam logic [IDW-1:0]  LAST_ID  = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 tx_done_q, tx_done_d;
  logic                 busy_timeout_q, busy_timeout_d;
  logic [IDW-1:0]       winner;

  // Round-robin scan starting at ptr. The index wraps by explicit compare so
  // a NUM_REQ that is not a power of two never visits a nonexistent slot.
  function automatic logic [IDW-1:0] pick_winner(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] idx;
    logic [IDW-1:0] win;
    logic           found;
    idx   = ptr;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = (idx == LAST_ID) ? '0 : idx + IDW'(1);
    end
    return win;
  endfunction

  assign winner = pick_winner(bus.req_valid, rr_ptr_q);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    tx_byte_d      = tx_byte_q;
    cnt_d          = cnt_q;
    req_ready_d    = '0;
    tx_start_d     = 1'b0;
    tx_done_d      = 1'b0;
    busy_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        // tx_busy high here means a frame is still on the wire (external, or
        // left over from before a reset); hold off until it ends.
        if (!bus.tx_busy && (|bus.req_valid)) begin
          tx_byte_d           = bus.req_data[8*winner +: 8];
          grant_id_d          = winner;
          req_ready_d[winner] = 1'b1;
          tx_start_d          = 1'b1;
          rr_ptr_d            = (winner == LAST_ID) ? '0 : winner + IDW'(1);
          state_d             = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == LAST_CNT) begin
          busy_timeout_d = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          tx_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      cnt_q          <= '0;
      req_ready_q    <= '0;
      tx_start_q     <= 1'b0;
      tx_byte_q      <= '0;
      tx_done_q      <= 1'b0;
      busy_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      cnt_q          <= cnt_d;
      req_ready_q    <= req_ready_d;
      tx_start_q     <= tx_start_d;
      tx_byte_q      <= tx_byte_d;
      tx_done_q      <= tx_done_d;
      busy_timeout_q <= busy_timeout_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_byte   = tx_byte_q;
  assign grant_id      = grant_id_q;
  assign tx_done       = tx_done_q;
  assign busy_timeout  = busy_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NUM_REQ=4, BUSY_TIMEOUT=16).
//   A small UART_TX stand-in raises tx_busy the cycle after tx_start, holds it
//   for FRAME_LEN cycles and then delivers the byte it latched to rx_q, acting
//   as the loopback receiver. tx_busy can instead be tied low or high.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int FRAME_LEN = 20;

  typedef enum logic [1:0] {M_MODEL, M_TIE0, M_TIE1} busy_mode_e;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant_id;
  logic       tx_done;
  logic       busy_timeout;

  busy_mode_e mode = M_MODEL;
  logic       model_busy = 1'b0;
  int         model_cnt = 0;
  logic [7:0] model_byte = 8'h00;
  logic [7:0] rx_q[$];

  int start_cnt = 0;
  int done_cnt  = 0;
  int checks    = 0;
  int errors    = 0;

  vec_t vecs[13];

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .grant_id     (grant_id),
    .tx_done      (tx_done),
    .busy_timeout (busy_timeout)
  );

  always #5 clk = ~clk;

  assign bus.tx_busy = (mode == M_MODEL) ? model_busy : (mode == M_TIE1);

  // UART_TX stand-in; like the real block it has no reset.
  always @(posedge clk) begin
    if (model_busy) begin
      if (model_cnt == 0) begin
        model_busy <= 1'b0;
        rx_q.push_back(model_byte);
      end else begin
        model_cnt <= model_cnt - 1;
      end
    end else if (mode == M_MODEL && bus.tx_start === 1'b1) begin
      model_busy <= 1'b1;
      model_cnt  <= FRAME_LEN - 1;
      model_byte <= bus.tx_byte;
    end
  end

  always @(posedge clk) begin
    start_cnt <= start_cnt + ((bus.tx_start === 1'b1) ? 1 : 0);
    done_cnt  <= done_cnt  + ((tx_done === 1'b1) ? 1 : 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // which: 0 = tx_start, 1 = tx_done, 2 = busy_timeout. Steps on negedges.
  task automatic wait_sig(input int which, input int budget, output logic hit, output int cycles);
    hit    = 1'b0;
    cycles = 0;
    while (!hit && cycles < budget) begin
      @(negedge clk);
      cycles++;
      case (which)
        0:       hit = (bus.tx_start === 1'b1);
        1:       hit = (tx_done === 1'b1);
        default: hit = (busy_timeout === 1'b1);
      endcase
    end
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'hxx;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    check(name, {24'h0, got}, {24'h0, exp});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},    {28'h0, bus.req_ready}, 32'h0);
    check({tag, "_tx_start"},     {31'h0, bus.tx_start},  32'h0);
    check({tag, "_tx_byte"},      {24'h0, bus.tx_byte},   32'h0);
    check({tag, "_grant_id"},     {30'h0, grant_id},      32'h0);
    check({tag, "_tx_done"},      {31'h0, tx_done},       32'h0);
    check({tag, "_busy_timeout"}, {31'h0, busy_timeout},  32'h0);
  endtask

  // Waits for the finished frame after a grant and checks the loopback byte.
  task automatic finish_frame(input string tag, input logic [7:0] exp_byte);
    logic hit;
    int   cyc;
    wait_sig(1, 60, hit, cyc);
    check({tag, "_done_seen"}, {31'h0, hit}, 32'h1);
    check_rx({tag, "_rx"}, exp_byte);
  endtask

  initial begin
    logic       hit;
    logic       prev_busy;
    int         cyc;
    int         snap;
    logic [1:0] cont_id[4];
    logic [7:0] cont_byte[4];

    vecs[0]  = '{4'b1111, 32'h13121110, 2'd0, 8'h10};
    vecs[1]  = '{4'b1110, 32'h13121110, 2'd1, 8'h11};
    vecs[2]  = '{4'b1100, 32'h13121110, 2'd2, 8'h12};
    vecs[3]  = '{4'b1000, 32'h13121110, 2'd3, 8'h13};
    vecs[4]  = '{4'b0001, 32'h0000004B, 2'd0, 8'h4B};
    vecs[5]  = '{4'b0101, 32'h00A200A0, 2'd2, 8'hA2};
    vecs[6]  = '{4'b0101, 32'h00A200A0, 2'd0, 8'hA0};
    vecs[7]  = '{4'b0101, 32'h00A200A0, 2'd2, 8'hA2};
    vecs[8]  = '{4'b0101, 32'h00A200A0, 2'd0, 8'hA0};
    vecs[9]  = '{4'b1001, 32'hB30000B0, 2'd3, 8'hB3};
    vecs[10] = '{4'b0110, 32'h00C2C100, 2'd1, 8'hC1};
    vecs[11] = '{4'b0010, 32'h0000D100, 2'd1, 8'hD1};
    vecs[12] = '{4'b1000, 32'hE3000000, 2'd3, 8'hE3};

    cont_id   = '{2'd0, 2'd2, 2'd0, 2'd2};
    cont_byte = '{8'hC0, 8'hC2, 8'hC1, 8'hC3};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Round-robin order across a stream of single grants.
    for (int i = 0; i < 13; i++) begin
      bus.req_valid = vecs[i].valid;
      bus.req_data  = vecs[i].data;
      wait_sig(0, 40, hit, cyc);
      check($sformatf("v%0d_start_latency", i), cyc, 1);
      check($sformatf("v%0d_grant_id", i), {30'h0, grant_id}, {30'h0, vecs[i].exp_id});
      check($sformatf("v%0d_tx_byte", i), {24'h0, bus.tx_byte}, {24'h0, vecs[i].exp_byte});
      check($sformatf("v%0d_req_ready", i), {28'h0, bus.req_ready}, 32'h1 << vecs[i].exp_id);
      bus.req_valid = '0;
      @(negedge clk);
      check($sformatf("v%0d_start_pulse", i), {31'h0, bus.tx_start}, 32'h0);
      check($sformatf("v%0d_ready_pulse", i), {28'h0, bus.req_ready}, 32'h0);
      finish_frame($sformatf("v%0d", i), vecs[i].exp_byte);
    end

    // Two requesters held valid continuously, data refreshed after each ready.
    bus.req_valid = 4'b0101;
    bus.req_data  = 32'h00C200C0;
    for (int k = 0; k < 4; k++) begin
      wait_sig(0, 40, hit, cyc);
      check($sformatf("cont%0d_start_latency", k), cyc, 1);
      check($sformatf("cont%0d_grant_id", k), {30'h0, grant_id}, {30'h0, cont_id[k]});
      check($sformatf("cont%0d_tx_byte", k), {24'h0, bus.tx_byte}, {24'h0, cont_byte[k]});
      if (grant_id == 2'd0) bus.req_data[7:0]   = bus.req_data[7:0] + 8'h1;
      else                  bus.req_data[23:16] = bus.req_data[23:16] + 8'h1;
      if (k == 3) bus.req_valid = '0;
      finish_frame($sformatf("cont%0d", k), cont_byte[k]);
    end

    // tx_busy never rises: timeout 16 cycles after leaving START, no tx_done.
    mode          = M_TIE0;
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h00005500;
    wait_sig(0, 40, hit, cyc);
    check("tmo_start_latency", cyc, 1);
    check("tmo_grant_id", {30'h0, grant_id}, 32'h1);
    bus.req_valid = '0;
    snap = done_cnt;
    wait_sig(2, 40, hit, cyc);
    check("tmo_cycles_from_start", cyc, 17);
    check("tmo_no_done", done_cnt - snap, 0);
    mode          = M_MODEL;
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000005A;
    wait_sig(0, 40, hit, cyc);
    check("tmo_pulse_width", {31'h0, busy_timeout}, 32'h0);
    check("tmo_back_to_idle", cyc, 1);
    check("tmo_next_grant_id", {30'h0, grant_id}, 32'h0);
    bus.req_valid = '0;
    finish_frame("tmo_next", 8'h5A);

    // Reset pulse during WAIT_DONE; the UART frame runs on.
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h00770000;
    wait_sig(0, 40, hit, cyc);
    check("rst_mid_grant_id", {30'h0, grant_id}, 32'h2);
    bus.req_valid = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst           = 1'b0;
    bus.req_valid = 4'b1001;
    bus.req_data  = 32'h99000088;
    snap          = done_cnt;
    prev_busy     = bus.tx_busy;
    hit           = 1'b0;
    cyc           = 0;
    while (!hit && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.tx_start === 1'b1) hit = 1'b1;
      else prev_busy = bus.tx_busy;
    end
    check("rst_mid_start_seen", {31'h0, hit}, 32'h1);
    check("rst_mid_held_off", {31'h0, (cyc > 1)}, 32'h1);
    check("rst_mid_busy_before_start", {31'h0, prev_busy}, 32'h0);
    check("rst_mid_grant_req0", {30'h0, grant_id}, 32'h0);
    check("rst_mid_tx_byte", {24'h0, bus.tx_byte}, 32'h88);
    check("rst_mid_no_done", done_cnt - snap, 0);
    check_rx("rst_mid_old_frame_rx", 8'h77);
    bus.req_valid = '0;
    finish_frame("rst_mid_next", 8'h88);

    // tx_busy high at reset release: no grant until it falls.
    mode          = M_TIE1;
    rst           = 1'b1;
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h00006600;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    snap = start_cnt;
    repeat (6) @(negedge clk);
    check("busy_rel_no_start", start_cnt - snap, 0);
    check("busy_rel_no_ready", {28'h0, bus.req_ready}, 32'h0);
    mode = M_TIE0;
    wait_sig(0, 10, hit, cyc);
    check("busy_rel_start_latency", cyc, 1);
    check("busy_rel_grant_id", {30'h0, grant_id}, 32'h1);
    mode          = M_MODEL;
    bus.req_valid = '0;
    finish_frame("busy_rel", 8'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
